// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and the hex-to-segment lookup for the
//            seven-segment display drivers.
// Contents : SEG_BLANK  - all segments off (active-low)
//            AN_OFF     - all anodes off (active-low)
//            hex2seg()  - nibble to active-low segment code, bit order gfedcba
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decode
// Purpose  : Purely combinational nibble to active-low segment decoder.
// Ports    : nibble_i [3:0] - hex digit
//            seg_o    [6:0] - segments, active-low, seg_o[0]=a .. seg_o[6]=g
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nibble_i);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Time-multiplexed 4-digit common-anode seven-segment driver with
//            hex decode, decimal points, optional leading-zero blanking and
//            an all-dark guard interval at the start of every digit slot.
// Params   : CNT_W    - refresh counter width, each slot lasts 2^CNT_W cycles
//            GUARD    - dark cycles at the start of each slot
//            BLANK_LZ - 1 blanks leading zero digits 3..1
// Ports    : clk, rst_n (async, active-low)
//            value_i [15:0] - value to show, [3:0] is the rightmost digit
//            load_i         - one-cycle capture strobe for value_i / dp_en_i
//            dp_en_i [3:0]  - decimal point enables, active-high
//            an_o    [3:0]  - anodes, active-low, one-hot-low
//            seg_o   [6:0]  - segments, active-low (gfedcba)
//            dp_o           - decimal point, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GUARD    = 256,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic [3:0]  dp_en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam logic [CNT_W-1:0] GUARD_C = GUARD[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [1:0]       idx_q,  idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       dpr_q,  dpr_d;
  logic [3:0]       an_q,   an_d;
  logic [6:0]       seg_q,  seg_d;
  logic             dp_q,   dp_d;

  logic [3:0]       nibble;
  logic [6:0]       nib_seg;
  logic             blank;
  logic             in_guard;

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (nib_seg)
  );

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (idx_q)
      2'd0: begin nibble = disp_q[3:0];                               end
      2'd1: begin nibble = disp_q[7:4];   blank = (disp_q[15:4]  == '0); end
      2'd2: begin nibble = disp_q[11:8];  blank = (disp_q[15:8]  == '0); end
      default: begin nibble = disp_q[15:12]; blank = (disp_q[15:12] == '0); end
    endcase
    if (!BLANK_LZ) blank = 1'b0;
  end

  assign in_guard = (cnt_q < GUARD_C);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    // Slot boundary: the digit index steps on the same edge the counter wraps.
    idx_d  = (&cnt_q) ? idx_q + 2'd1 : idx_q;
    disp_d = load_i ? value_i : disp_q;
    dpr_d  = load_i ? dp_en_i : dpr_q;

    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    if (!in_guard) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? SEG_BLANK : nib_seg;
      // The decimal point stays visible even on a blanked digit.
      dp_d  = ~dpr_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      disp_q <= 16'h0000;
      dpr_q  <= 4'h0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      dpr_q  <= dpr_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Directed self-checking bench for seg7_scan. Two instances share
//            stimulus: u_dut0 without blanking, u_dut1 with leading-zero
//            blanking. CNT_W=4, GUARD=2: 16-cycle slots, 64-cycle frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_en;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  int n_tests;
  int n_fail;

  seg7_scan #(.CNT_W(4), .GUARD(2), .BLANK_LZ(1'b0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value),
    .load_i  (load),
    .dp_en_i (dp_en),
    .an_o    (an0),
    .seg_o   (seg0),
    .dp_o    (dp0)
  );

  seg7_scan #(.CNT_W(4), .GUARD(2), .BLANK_LZ(1'b1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value),
    .load_i  (load),
    .dp_en_i (dp_en),
    .an_o    (an1),
    .seg_o   (seg1),
    .dp_o    (dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, released at a falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load strobe sampled at the next rising edge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_en = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({an0, seg0, dp0} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_hold: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an0, seg0, dp0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      exp_an = (e >= 3 && e <= 16) ? 4'hE : 4'hF;
      n_tests++;
      if (an0 !== exp_an) begin
        n_fail++;
        $display("FAIL reset_first_anode edge %0d: an=%h, want %h", e, an0, exp_an);
      end
    end
  endtask

  task automatic test_frame();
    logic [3:0] t_an  [4];
    logic [6:0] t_seg [4];
    logic       t_dp  [4];
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    int slot, c;
    t_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    t_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    t_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    do_load(16'h12AF, 4'b0100);
    for (int e = 2; e <= 64; e++) begin
      tick();
      slot = (e - 1) / 16;
      c    = (e - 1) % 16;
      if (c < 2) begin
        x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1;
      end else begin
        x_an = t_an[slot]; x_seg = t_seg[slot]; x_dp = t_dp[slot];
      end
      n_tests++;
      if ({an0, seg0, dp0} !== {x_an, x_seg, x_dp}) begin
        n_fail++;
        $display("FAIL frame_12AF edge %0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 e, an0, seg0, dp0, x_an, x_seg, x_dp);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] t_an [4];
    logic [3:0] x_an;
    logic [6:0] x_seg1, x_seg0;
    int slot, c;
    t_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    do_reset();
    do_load(16'h0003, 4'b0000);
    for (int e = 2; e <= 64; e++) begin
      tick();
      slot = (e - 1) / 16;
      c    = (e - 1) % 16;
      if (c < 2) begin
        x_an = 4'hF; x_seg1 = 7'h7F; x_seg0 = 7'h7F;
      end else begin
        x_an   = t_an[slot];
        x_seg1 = (slot == 0) ? 7'h30 : 7'h7F;
        x_seg0 = (slot == 0) ? 7'h30 : 7'h40;
      end
      n_tests++;
      if ({an1, seg1, dp1} !== {x_an, x_seg1, 1'b1}) begin
        n_fail++;
        $display("FAIL blank_0003 edge %0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 e, an1, seg1, dp1, x_an, x_seg1);
      end
      n_tests++;
      if ({an0, seg0} !== {x_an, x_seg0}) begin
        n_fail++;
        $display("FAIL noblank_0003 edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 e, an0, seg0, x_an, x_seg0);
      end
    end
    do_load(16'h0000, 4'b0000);  // load edge 65
    for (int e = 66; e <= 80; e++) begin
      tick();
      x_an   = (e >= 67) ? 4'hE  : 4'hF;
      x_seg1 = (e >= 67) ? 7'h40 : 7'h7F;
      n_tests++;
      if ({an1, seg1} !== {x_an, x_seg1}) begin
        n_fail++;
        $display("FAIL blank_zero edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 e, an1, seg1, x_an, x_seg1);
      end
    end
  endtask

  task automatic test_midload();
    do_reset();
    do_load(16'h0008, 4'b0000);          // edge 1
    repeat (7) tick();                   // edge 8
    n_tests++;
    if ({an0, seg0} !== {4'hE, 7'h00}) begin
      n_fail++;
      $display("FAIL midload_before: an=%h seg=%h, want an=E seg=00", an0, seg0);
    end
    do_load(16'h0009, 4'b0000);          // load edge 9, output still old data
    n_tests++;
    if ({an0, seg0} !== {4'hE, 7'h00}) begin
      n_fail++;
      $display("FAIL midload_edge: an=%h seg=%h, want an=E seg=00", an0, seg0);
    end
    tick();                              // edge 10 shows new data
    n_tests++;
    if ({an0, seg0} !== {4'hE, 7'h10}) begin
      n_fail++;
      $display("FAIL midload_after: an=%h seg=%h, want an=E seg=10", an0, seg0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (63) tick();                  // edge 63
    do_load(16'h000E, 4'b0000);          // edge 64: idx wraps 3->0
    n_tests++;
    if ({an0, seg0} !== {4'h7, 7'h40}) begin
      n_fail++;
      $display("FAIL wrap_last_digit3: an=%h seg=%h, want an=7 seg=40", an0, seg0);
    end
    for (int e = 65; e <= 67; e++) begin
      tick();
      n_tests++;
      if (e < 67 && {an0, seg0} !== {4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL wrap_guard edge %0d: an=%h seg=%h, want an=F seg=7F", e, an0, seg0);
      end else if (e == 67 && {an0, seg0} !== {4'hE, 7'h06}) begin
        n_fail++;
        $display("FAIL wrap_first_drive: an=%h seg=%h, want an=E seg=06", an0, seg0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_load(16'h1234, 4'b0000);          // edge 1
    repeat (39) tick();                  // edge 40: digit 2, drive phase
    n_tests++;
    if ({an0, seg0} !== {4'hB, 7'h24}) begin
      n_fail++;
      $display("FAIL resetmid_pre: an=%h seg=%h, want an=B seg=24", an0, seg0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an0, seg0, dp0} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL resetmid_async: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an0, seg0, dp0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_tests++;
      if (e < 3 && {an0, seg0} !== {4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL resetmid_guard edge %0d: an=%h seg=%h, want an=F seg=7F", e, an0, seg0);
      end else if (e == 3 && {an0, seg0} !== {4'hE, 7'h40}) begin
        n_fail++;
        $display("FAIL resetmid_restart: an=%h seg=%h, want an=E seg=40", an0, seg0);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    value   = 16'h0000;
    load    = 1'b0;
    dp_en   = 4'h0;
    test_reset();
    test_frame();
    test_blank();
    test_midload();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
